// File: rtl/lv1_trig_pkg.sv
// Shared constants and enums for the lv1 trigger pipeline and its tag serializer.
// Tag logic in the top is built only when TRIG_TAG_EN is defined.
package lv1_trig_pkg;

  localparam int LV1_CNT_W   = 20;
  localparam int REJ_CNT_W   = 32;
  localparam int ABORT_CNT_W = 16;
  localparam int EVT_ID_W    = 10;
  localparam int TAG_W       = 16;

  localparam logic [TAG_W-1:0] TAG_HDR = 16'hEEEE;

  typedef enum logic [3:0] {
    TW_HDR     = 4'd0,
    TW_ID      = 4'd1,
    TW_VETO_LO = 4'd2,
    TW_VETO_HI = 4'd3,
    TW_TS_LO   = 4'd4,
    TW_TS_HI   = 4'd5,
    TW_TRIG    = 4'd6,
    TW_FLAGS   = 4'd7,
    TW_ET      = 4'd8
  } tag_word_e;

  localparam tag_word_e TW_LAST = TW_ET;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tag_state_e;

  function automatic tag_word_e tw_next(input tag_word_e w);
    return tag_word_e'(w + 4'd1);
  endfunction

endpackage

// File: rtl/lv1_tag_serializer.sv
// Tag-ADC word serializer: snapshots the trigger inputs on accept and streams a
// 9-word frame, one word per clock. Instantiated only under TRIG_TAG_EN.
//
// state   | meaning
// ST_IDLE | no frame in progress, output held at 0
// ST_SEND | streaming frame words from the snapshot
module lv1_tag_serializer
  import lv1_trig_pkg::*;
#(
  parameter int N_INT = 8,
  parameter int N_EXT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_cnt_clr,
  input  logic                   i_accept,
  input  logic                   i_ps,
  input  logic [N_INT-1:0]       i_int_raw,
  input  logic [N_INT-1:0]       i_int_scaled,
  input  logic [N_EXT-1:0]       i_ext,
  input  logic                   i_delta,
  input  logic [15:0]            i_et_raw,
  input  logic [31:0]            i_veto_raw,
  input  logic [3:0]             i_nclus,
  input  logic [31:0]            i_timestamp,
  output logic [TAG_W-1:0]       o_trig_tag,
  output logic [ABORT_CNT_W-1:0] o_abort_cnt
);

  tag_state_e             r_state;
  tag_word_e              r_idx;
  logic [TAG_W-1:0]       r_tag;
  logic [ABORT_CNT_W-1:0] r_abort_cnt;
  logic [EVT_ID_W-1:0]    r_evt_id;
  logic [EVT_ID_W-1:0]    r_snap_id;
  logic [31:0]            r_snap_veto;
  logic [31:0]            r_snap_ts;
  logic [15:0]            r_snap_et;
  logic [15:0]            r_snap_trig;
  logic [15:0]            r_snap_flags;

  logic [15:0]            w_trig_word;
  logic [15:0]            w_flag_word;
  tag_word_e              w_next_idx;
  logic [TAG_W-1:0]       w_word;
  logic                   w_truncate;

  assign w_trig_word = 16'({i_int_scaled, i_int_raw});
  assign w_flag_word = 16'({i_ps, i_delta, i_ext, i_nclus});
  assign w_next_idx  = tw_next(r_idx);
  // A restart on the last word still delivered a complete frame
  assign w_truncate  = i_accept && (r_state == ST_SEND) && (r_idx != TW_LAST);

  always_comb begin
    w_word = '0;
    case (w_next_idx)
      TW_HDR:     w_word = TAG_HDR;
      TW_ID:      w_word = 16'(r_snap_id);
      TW_VETO_LO: w_word = r_snap_veto[15:0];
      TW_VETO_HI: w_word = r_snap_veto[31:16];
      TW_TS_LO:   w_word = r_snap_ts[15:0];
      TW_TS_HI:   w_word = r_snap_ts[31:16];
      TW_TRIG:    w_word = r_snap_trig;
      TW_FLAGS:   w_word = r_snap_flags;
      TW_ET:      w_word = r_snap_et;
      default:    w_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= TW_HDR;
      r_tag        <= '0;
      r_abort_cnt  <= '0;
      r_evt_id     <= '0;
      r_snap_id    <= '0;
      r_snap_veto  <= '0;
      r_snap_ts    <= '0;
      r_snap_et    <= '0;
      r_snap_trig  <= '0;
      r_snap_flags <= '0;
    end else begin
      if (i_cnt_clr)
        r_abort_cnt <= '0;
      else if (w_truncate && (r_abort_cnt != '1))
        r_abort_cnt <= r_abort_cnt + ABORT_CNT_W'(1);

      if (i_clear) begin
        r_state  <= ST_IDLE;
        r_idx    <= TW_HDR;
        r_tag    <= '0;
        r_evt_id <= '0;
      end else if (i_accept) begin
        r_snap_id    <= r_evt_id;
        r_snap_veto  <= i_veto_raw;
        r_snap_ts    <= i_timestamp;
        r_snap_et    <= i_et_raw;
        r_snap_trig  <= w_trig_word;
        r_snap_flags <= w_flag_word;
        r_evt_id     <= r_evt_id + EVT_ID_W'(1);
        r_state      <= ST_SEND;
        r_idx        <= TW_HDR;
        r_tag        <= TAG_HDR;
      end else if (r_state == ST_SEND) begin
        if (r_idx == TW_LAST) begin
          r_state <= ST_IDLE;
          r_idx   <= TW_HDR;
          r_tag   <= '0;
        end else begin
          r_idx <= w_next_idx;
          r_tag <= w_word;
        end
      end
    end
  end

  assign o_trig_tag  = r_tag;
  assign o_abort_cnt = r_abort_cnt;

endmodule

// File: rtl/lv1_trig_pipe.sv
// Level-1 trigger delay pipeline with ps-flag FIFO, inhibit window and counters.
// Define TRIG_TAG_EN to build the tag-ADC serializer; otherwise its outputs are tied 0.
module lv1_trig_pipe
  import lv1_trig_pkg::*;
#(
  parameter int PIPE_DEPTH = 256,
  parameter int N_INT      = 8,
  parameter int N_EXT      = 4,
  parameter int PS_DEPTH   = 16,
  parameter int INH_PRE    = 4,
  parameter int INH_LEN    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_live,
  input  logic                          in_lv1b_req,
  input  logic [N_INT-1:0]              in_int_raw,
  input  logic [N_INT-1:0]              in_int_scaled,
  input  logic [N_EXT-1:0]              in_ext,
  input  logic                          in_delta,
  input  logic [15:0]                   in_et_raw,
  input  logic [31:0]                   in_veto_raw,
  input  logic [3:0]                    in_nclus,
  input  logic [31:0]                   in_timestamp,
  input  logic [N_INT-1:0]              user_ps,
  input  logic [$clog2(PIPE_DEPTH)-1:0] delay_lv1,
  input  logic                          lv2_full,
  output logic                          out_lv1,
  output logic                          out_lv1_inhibit,
  output logic                          out_early_lv1,
  output logic [TAG_W-1:0]              out_trig_tag,
  output logic [LV1_CNT_W-1:0]          lv1_cnt,
  output logic [LV1_CNT_W-1:0]          lv1_cnt_ps,
  output logic [REJ_CNT_W-1:0]          lv2_rej_cnt,
  output logic [ABORT_CNT_W-1:0]        tag_abort_cnt,
  output logic                          ps_ovf
);

  localparam int DW    = $clog2(PIPE_DEPTH);
  localparam int PW    = $clog2(PS_DEPTH);
  localparam int D_MIN = (INH_PRE < 1) ? 1 : INH_PRE;
  localparam int D_MAX = PIPE_DEPTH - 2;
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(PS_DEPTH);

  logic [PIPE_DEPTH-1:0] r_pipe;
  logic [PS_DEPTH-1:0]   r_fifo;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_fifo_cnt;
  logic                  r_live_d;
  logic                  r_early;
  logic                  r_lv1;
  logic                  r_inh;
  logic                  r_ps_ovf;
  logic [LV1_CNT_W-1:0]  r_lv1_cnt;
  logic [LV1_CNT_W-1:0]  r_lv1_cnt_ps;
  logic [REJ_CNT_W-1:0]  r_rej_cnt;

  logic [DW-1:0]         w_d;
  logic [DW-1:0]         w_d1;
  logic [PIPE_DEPTH-1:0] w_pipe_nxt;
  logic [PIPE_DEPTH-1:0] w_inh_mask;
  logic                  w_fifo_full;
  logic                  w_qual;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_ps;
  logic                  w_pop;
  logic                  w_head_ps;
  logic                  w_ps_ext;
  logic                  w_lv1_nxt;
  logic                  w_inh_nxt;
  logic                  w_live_rise;

  always_comb begin
    if (delay_lv1 < DW'(D_MIN))
      w_d = DW'(D_MIN);
    else if (delay_lv1 > DW'(D_MAX))
      w_d = DW'(D_MAX);
    else
      w_d = delay_lv1;
  end

  assign w_d1 = w_d + DW'(1);

  always_comb begin
    w_inh_mask = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if ((i >= int'(w_d) - INH_PRE) && (i < int'(w_d) - INH_PRE + INH_LEN))
        w_inh_mask[i] = 1'b1;
    end
  end

  assign w_fifo_full = (r_fifo_cnt == FIFO_FULL);
  assign w_qual      = in_live && in_lv1b_req && ((|in_int_scaled) || (|in_ext) || in_delta);
  assign w_accept    = w_qual && !lv2_full && !w_fifo_full;
  assign w_reject    = w_qual && (lv2_full || w_fifo_full);
  assign w_ps        = (|in_int_scaled) && !(|(in_int_scaled & ~user_ps)) && !(|in_ext);

  assign w_pop      = in_live && r_pipe[w_d1] && (r_fifo_cnt != '0);
  assign w_head_ps  = r_fifo[r_rd_ptr];
  // The marker about to reach D+1 owns the head entry unless the head is popping now
  assign w_ps_ext   = r_pipe[w_d1] ? r_fifo[r_rd_ptr + PW'(1)] : w_head_ps;

  assign w_pipe_nxt  = {r_pipe[PIPE_DEPTH-2:0], w_accept};
  assign w_lv1_nxt   = w_pipe_nxt[w_d] || (w_pipe_nxt[w_d1] && w_ps_ext);
  assign w_inh_nxt   = |(w_pipe_nxt & w_inh_mask);
  assign w_live_rise = in_live && !r_live_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe     <= '0;
      r_live_d   <= 1'b0;
      r_early    <= 1'b0;
      r_lv1      <= 1'b0;
      r_inh      <= 1'b0;
    end else begin
      r_live_d <= in_live;
      r_early  <= w_accept;
      r_lv1    <= in_live && w_lv1_nxt;
      r_inh    <= in_live && w_inh_nxt;
      r_pipe   <= in_live ? w_pipe_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (!in_live) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= w_ps;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (PW+1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (PW+1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lv1_cnt    <= '0;
      r_lv1_cnt_ps <= '0;
      r_rej_cnt    <= '0;
      r_ps_ovf     <= 1'b0;
    end else begin
      if (w_live_rise) begin
        r_lv1_cnt    <= '0;
        r_lv1_cnt_ps <= '0;
        r_rej_cnt    <= '0;
      end else begin
        if (w_pop)
          r_lv1_cnt <= r_lv1_cnt + LV1_CNT_W'(1);
        if (w_pop && w_head_ps)
          r_lv1_cnt_ps <= r_lv1_cnt_ps + LV1_CNT_W'(1);
        if (w_reject && (r_rej_cnt != '1))
          r_rej_cnt <= r_rej_cnt + REJ_CNT_W'(1);
      end

      if (!in_live)
        r_ps_ovf <= 1'b0;
      else if (w_reject && w_fifo_full)
        r_ps_ovf <= 1'b1;
    end
  end

  assign out_lv1         = r_lv1;
  assign out_lv1_inhibit = r_inh;
  assign out_early_lv1   = r_early;
  assign lv1_cnt         = r_lv1_cnt;
  assign lv1_cnt_ps      = r_lv1_cnt_ps;
  assign lv2_rej_cnt     = r_rej_cnt;
  assign ps_ovf          = r_ps_ovf;

`ifdef TRIG_TAG_EN
  lv1_tag_serializer #(
    .N_INT (N_INT),
    .N_EXT (N_EXT)
  ) u_tag (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (!in_live),
    .i_cnt_clr    (w_live_rise),
    .i_accept     (w_accept),
    .i_ps         (w_ps),
    .i_int_raw    (in_int_raw),
    .i_int_scaled (in_int_scaled),
    .i_ext        (in_ext),
    .i_delta      (in_delta),
    .i_et_raw     (in_et_raw),
    .i_veto_raw   (in_veto_raw),
    .i_nclus      (in_nclus),
    .i_timestamp  (in_timestamp),
    .o_trig_tag   (out_trig_tag),
    .o_abort_cnt  (tag_abort_cnt)
  );
`else
  logic w_tag_unused;
  assign w_tag_unused  = ^{in_int_raw, in_et_raw, in_veto_raw, in_nclus, in_timestamp};
  assign out_trig_tag  = '0;
  assign tag_abort_cnt = '0;
`endif

endmodule

// File: tb/tb_lv1_trig_pipe.sv
// Directed self-checking bench for lv1_trig_pipe (default parameters).
module tb_lv1_trig_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_live = 1'b0;
  logic        in_lv1b_req = 1'b0;
  logic [7:0]  in_int_raw = '0;
  logic [7:0]  in_int_scaled = '0;
  logic [3:0]  in_ext = '0;
  logic        in_delta = 1'b0;
  logic [15:0] in_et_raw = '0;
  logic [31:0] in_veto_raw = '0;
  logic [3:0]  in_nclus = '0;
  logic [31:0] in_timestamp = '0;
  logic [7:0]  user_ps = '0;
  logic [7:0]  delay_lv1 = 8'd20;
  logic        lv2_full = 1'b0;
  logic        out_lv1;
  logic        out_lv1_inhibit;
  logic        out_early_lv1;
  logic [15:0] out_trig_tag;
  logic [19:0] lv1_cnt;
  logic [19:0] lv1_cnt_ps;
  logic [31:0] lv2_rej_cnt;
  logic [15:0] tag_abort_cnt;
  logic        ps_ovf;

  int checks = 0;
  int errors = 0;

  lv1_trig_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_live         (in_live),
    .in_lv1b_req     (in_lv1b_req),
    .in_int_raw      (in_int_raw),
    .in_int_scaled   (in_int_scaled),
    .in_ext          (in_ext),
    .in_delta        (in_delta),
    .in_et_raw       (in_et_raw),
    .in_veto_raw     (in_veto_raw),
    .in_nclus        (in_nclus),
    .in_timestamp    (in_timestamp),
    .user_ps         (user_ps),
    .delay_lv1       (delay_lv1),
    .lv2_full        (lv2_full),
    .out_lv1         (out_lv1),
    .out_lv1_inhibit (out_lv1_inhibit),
    .out_early_lv1   (out_early_lv1),
    .out_trig_tag    (out_trig_tag),
    .lv1_cnt         (lv1_cnt),
    .lv1_cnt_ps      (lv1_cnt_ps),
    .lv2_rej_cnt     (lv2_rej_cnt),
    .tag_abort_cnt   (tag_abort_cnt),
    .ps_ovf          (ps_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    in_lv1b_req   = 1'b0;
    in_int_scaled = '0;
    in_ext        = '0;
    in_delta      = 1'b0;
  endtask

  // Present one request for a single edge; returns one tick after that edge.
  task automatic issue(input logic [7:0] sc, input logic [3:0] ex, input logic dl);
    in_int_scaled = sc;
    in_ext        = ex;
    in_delta      = dl;
    in_lv1b_req   = 1'b1;
    step();
    clear_req();
  endtask

  task automatic restart_live();
    in_live = 1'b0;
    step();
    step();
    in_live = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_live = 1'b1;
    in_lv1b_req = 1'b1;
    in_ext = 4'h1;
    step();
    step();
    step();
    checks++; if (out_lv1 !== 1'b0) begin errors++; $display("FAIL reset_lv1 got %0b exp 0", out_lv1); end
    checks++; if (out_early_lv1 !== 1'b0) begin errors++; $display("FAIL reset_early got %0b exp 0", out_early_lv1); end
    checks++; if (out_lv1_inhibit !== 1'b0) begin errors++; $display("FAIL reset_inh got %0b exp 0", out_lv1_inhibit); end
    checks++; if (out_trig_tag !== 16'h0) begin errors++; $display("FAIL reset_tag got %h exp 0", out_trig_tag); end
    checks++; if (lv1_cnt !== 20'd0) begin errors++; $display("FAIL reset_lv1_cnt got %0d exp 0", lv1_cnt); end
    checks++; if (lv2_rej_cnt !== 32'd0) begin errors++; $display("FAIL reset_rej got %0d exp 0", lv2_rej_cnt); end
    checks++; if (ps_ovf !== 1'b0) begin errors++; $display("FAIL reset_ps_ovf got %0b exp 0", ps_ovf); end
    clear_req();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_lv1();
    restart_live();
    delay_lv1 = 8'd20;
    issue(8'h00, 4'h2, 1'b0);
    for (int off = 1; off <= 35; off++) begin
      checks++; if (out_early_lv1 !== (off == 1)) begin errors++; $display("FAIL single_early off %0d got %0b exp %0b", off, out_early_lv1, off == 1); end
      checks++; if (out_lv1 !== (off == 21)) begin errors++; $display("FAIL single_lv1 off %0d got %0b exp %0b", off, out_lv1, off == 21); end
      checks++; if (out_lv1_inhibit !== (off >= 17 && off <= 24)) begin errors++; $display("FAIL single_inh off %0d got %0b exp %0b", off, out_lv1_inhibit, off >= 17 && off <= 24); end
      step();
    end
    checks++; if (lv1_cnt !== 20'd1) begin errors++; $display("FAIL single_lv1_cnt got %0d exp 1", lv1_cnt); end
    checks++; if (lv1_cnt_ps !== 20'd0) begin errors++; $display("FAIL single_cnt_ps got %0d exp 0", lv1_cnt_ps); end
  endtask

  task automatic test_ps_flag();
    logic [7:0] sc_v  [6] = '{8'h02, 8'h04, 8'h00, 8'h01, 8'h81, 8'h10};
    logic [7:0] ups_v [6] = '{8'h03, 8'h03, 8'hFF, 8'hFF, 8'h81, 8'h10};
    logic [3:0] ext_v [6] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    logic       dl_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] dly_v [6] = '{8'd20, 8'd20, 8'd0, 8'd3, 8'd255, 8'd5};
    int         off_v [6] = '{21, 21, 5, 5, 255, 6};
    int         w_v   [6] = '{2, 1, 1, 1, 2, 2};
    logic [19:0] ps_v [6] = '{20'd1, 20'd0, 20'd0, 20'd0, 20'd1, 20'd1};
    int first;
    int width;
    for (int v = 0; v < 6; v++) begin
      restart_live();
      checks++; if (lv1_cnt !== 20'd0) begin errors++; $display("FAIL ps_cnt_clear v%0d got %0d exp 0", v, lv1_cnt); end
      user_ps   = ups_v[v];
      delay_lv1 = dly_v[v];
      issue(sc_v[v], ext_v[v], dl_v[v]);
      first = -1;
      width = 0;
      for (int off = 1; off <= off_v[v] + 8; off++) begin
        if (out_lv1 === 1'b1) begin
          width++;
          if (first < 0) first = off;
        end
        step();
      end
      checks++; if (first != off_v[v]) begin errors++; $display("FAIL ps_lv1_start v%0d got %0d exp %0d", v, first, off_v[v]); end
      checks++; if (width != w_v[v]) begin errors++; $display("FAIL ps_lv1_width v%0d got %0d exp %0d", v, width, w_v[v]); end
      checks++; if (lv1_cnt !== 20'd1) begin errors++; $display("FAIL ps_lv1_cnt v%0d got %0d exp 1", v, lv1_cnt); end
      checks++; if (lv1_cnt_ps !== ps_v[v]) begin errors++; $display("FAIL ps_cnt_ps v%0d got %0d exp %0d", v, lv1_cnt_ps, ps_v[v]); end
    end
    user_ps = '0;
  endtask

  task automatic test_lv2_full();
    int n_lv1;
    int n_early;
    restart_live();
    delay_lv1 = 8'd20;
    lv2_full  = 1'b1;
    n_lv1 = 0;
    n_early = 0;
    for (int i = 0; i < 5; i++) begin
      issue(8'h00, 4'h1, 1'b0);
      if (out_early_lv1 === 1'b1) n_early++;
    end
    lv2_full = 1'b0;
    for (int off = 0; off < 40; off++) begin
      if (out_lv1 === 1'b1) n_lv1++;
      if (out_early_lv1 === 1'b1) n_early++;
      step();
    end
    checks++; if (n_lv1 != 0) begin errors++; $display("FAIL lv2full_lv1 got %0d exp 0", n_lv1); end
    checks++; if (n_early != 0) begin errors++; $display("FAIL lv2full_early got %0d exp 0", n_early); end
    checks++; if (lv2_rej_cnt !== 32'd5) begin errors++; $display("FAIL lv2full_rej got %0d exp 5", lv2_rej_cnt); end
    checks++; if (lv1_cnt !== 20'd0) begin errors++; $display("FAIL lv2full_lv1_cnt got %0d exp 0", lv1_cnt); end
    checks++; if (ps_ovf !== 1'b0) begin errors++; $display("FAIL lv2full_ps_ovf got %0b exp 0", ps_ovf); end
  endtask

  task automatic test_fifo_ovf();
    int n_lv1;
    int n_early;
    restart_live();
    delay_lv1 = 8'd200;
    n_lv1 = 0;
    n_early = 0;
    in_ext = 4'h1;
    in_lv1b_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (out_early_lv1 === 1'b1) n_early++;
    end
    clear_req();
    checks++; if (ps_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", ps_ovf); end
    for (int off = 0; off < 230; off++) begin
      if (out_lv1 === 1'b1) n_lv1++;
      step();
    end
    checks++; if (n_early != 16) begin errors++; $display("FAIL ovf_early got %0d exp 16", n_early); end
    checks++; if (n_lv1 != 16) begin errors++; $display("FAIL ovf_lv1 got %0d exp 16", n_lv1); end
    checks++; if (lv2_rej_cnt !== 32'd1) begin errors++; $display("FAIL ovf_rej got %0d exp 1", lv2_rej_cnt); end
    checks++; if (lv1_cnt !== 20'd16) begin errors++; $display("FAIL ovf_lv1_cnt got %0d exp 16", lv1_cnt); end
    checks++; if (ps_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", ps_ovf); end
    in_live = 1'b0;
    step();
    checks++; if (ps_ovf !== 1'b0) begin errors++; $display("FAIL ovf_live_clear got %0b exp 0", ps_ovf); end
  endtask

  task automatic test_live_flush();
    int n_lv1;
    int n_inh;
    restart_live();
    delay_lv1 = 8'd20;
    issue(8'h00, 4'h4, 1'b0);
    for (int i = 0; i < 5; i++) step();
    in_live = 1'b0;
    step();
    step();
    step();
    in_live = 1'b1;
    n_lv1 = 0;
    n_inh = 0;
    for (int off = 0; off < 40; off++) begin
      if (out_lv1 === 1'b1) n_lv1++;
      if (out_lv1_inhibit === 1'b1) n_inh++;
      step();
    end
    checks++; if (n_lv1 != 0) begin errors++; $display("FAIL flush_lv1 got %0d exp 0", n_lv1); end
    checks++; if (n_inh != 0) begin errors++; $display("FAIL flush_inh got %0d exp 0", n_inh); end
    checks++; if (lv1_cnt !== 20'd0) begin errors++; $display("FAIL flush_lv1_cnt got %0d exp 0", lv1_cnt); end
  endtask

  task automatic test_reset_midflight();
    int n_lv1;
    restart_live();
    lv2_full = 1'b1;
    issue(8'h00, 4'h1, 1'b0);
    lv2_full = 1'b0;
    delay_lv1 = 8'd50;
    issue(8'h00, 4'h1, 1'b0);
    for (int i = 0; i < 10; i++) step();
    checks++; if (lv2_rej_cnt !== 32'd1) begin errors++; $display("FAIL midrst_pre_rej got %0d exp 1", lv2_rej_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (lv2_rej_cnt !== 32'd0) begin errors++; $display("FAIL midrst_rej got %0d exp 0", lv2_rej_cnt); end
    checks++; if (lv1_cnt !== 20'd0) begin errors++; $display("FAIL midrst_lv1_cnt got %0d exp 0", lv1_cnt); end
    checks++; if (out_early_lv1 !== 1'b0) begin errors++; $display("FAIL midrst_early got %0b exp 0", out_early_lv1); end
    step();
    step();
    rst_n = 1'b1;
    n_lv1 = 0;
    for (int off = 0; off < 60; off++) begin
      if (out_lv1 === 1'b1) n_lv1++;
      step();
    end
    checks++; if (n_lv1 != 0) begin errors++; $display("FAIL midrst_lv1 got %0d exp 0", n_lv1); end
    checks++; if (lv1_cnt !== 20'd0) begin errors++; $display("FAIL midrst_post_cnt got %0d exp 0", lv1_cnt); end
  endtask

`ifdef TRIG_TAG_EN
  task automatic test_tag_frame();
    logic [15:0] exp_w [13] = '{16'hEEEE, 16'h0000, 16'h5A5A,
                                16'hEEEE, 16'h0001, 16'hF0F0, 16'h0F0F, 16'hBABE,
                                16'hCAFE, 16'h0044, 16'h0197, 16'h1234, 16'h0000};
    restart_live();
    delay_lv1    = 8'd20;
    user_ps      = 8'h03;
    in_veto_raw  = 32'hA5A5_5A5A;
    in_timestamp = 32'h1234_5678;
    in_et_raw    = 16'h0BEE;
    in_nclus     = 4'h3;
    in_int_raw   = 8'h11;
    issue(8'h02, 4'h0, 1'b0);
    for (int off = 1; off <= 13; off++) begin
      checks++; if (out_trig_tag !== exp_w[off-1]) begin errors++; $display("FAIL tag_word off %0d got %h exp %h", off, out_trig_tag, exp_w[off-1]); end
      if (off == 3) begin
        in_veto_raw   = 32'h0F0F_F0F0;
        in_timestamp  = 32'hCAFE_BABE;
        in_et_raw     = 16'h1234;
        in_nclus      = 4'h7;
        in_int_raw    = 8'h44;
        in_int_scaled = 8'h00;
        in_ext        = 4'h9;
        in_delta      = 1'b1;
        in_lv1b_req   = 1'b1;
      end else begin
        clear_req();
      end
      step();
    end
    checks++; if (tag_abort_cnt !== 16'd1) begin errors++; $display("FAIL tag_abort got %0d exp 1", tag_abort_cnt); end
    user_ps = '0;
  endtask
`else
  task automatic test_tag_frame();
    restart_live();
    delay_lv1   = 8'd20;
    in_veto_raw = 32'hA5A5_5A5A;
    issue(8'h00, 4'h1, 1'b0);
    for (int off = 1; off <= 12; off++) begin
      checks++; if (out_trig_tag !== 16'h0) begin errors++; $display("FAIL tag_off off %0d got %h exp 0", off, out_trig_tag); end
      if (off == 2) in_lv1b_req = 1'b1; else clear_req();
      if (off == 2) in_ext = 4'h1;
      step();
    end
    checks++; if (tag_abort_cnt !== 16'd0) begin errors++; $display("FAIL tag_off_abort got %0d exp 0", tag_abort_cnt); end
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_lv1();
    test_ps_flag();
    test_lv2_full();
    test_fifo_ovf();
    test_live_flush();
    test_reset_midflight();
    test_tag_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
